// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave responder, oversampled in the shared system clock domain.
// Serial RX/TX characters are buffered in small first-word-fall-through FIFOs
// behind valid/ready handshakes.

// Synchronous first-word-fall-through FIFO used for both RX and TX paths.
module spi_slave_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign push_ok  = push && (!full || pop_ok);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module spi_slave_responder #(
    parameter int unsigned          CHAR_LEN    = 8,
    parameter int unsigned          FIFO_DEPTH  = 4,
    parameter logic [CHAR_LEN-1:0]  TX_IDLE_PAT = 8'hFF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                spi_ss_i,
    input  logic                spi_sclk_i,
    input  logic                spi_mosi_i,
    output logic                spi_miso_o,
    input  logic [CHAR_LEN-1:0] tx_data_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    output logic [CHAR_LEN-1:0] rx_data_o,
    output logic                rx_valid_o,
    input  logic                rx_ready_i,
    output logic                rx_overrun_o,
    output logic                tx_underrun_o,
    output logic                busy_o
);
    localparam int unsigned CNT_W = $clog2(CHAR_LEN + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [0:0]          state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CHAR_LEN-1:0] rx_sr;
    logic [CHAR_LEN-1:0] tx_sr;

    logic ss_s1, ss_s2, ss_d;
    logic sclk_s1, sclk_s2, sclk_d;
    logic mosi_s1, mosi_s2;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic                tx_load;
    logic                rx_complete;
    logic                tx_pop;
    logic                rx_pop;
    logic                rx_overrun_set;
    logic [CHAR_LEN-1:0] tx_head;
    logic [CHAR_LEN-1:0] tx_load_val;
    logic [CHAR_LEN-1:0] rx_char;
    logic                tx_full, tx_empty;
    logic                rx_full, rx_empty;

    // Two-flop synchronizers plus a delayed copy of ss/sclk for edge detection.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ss_s1   <= spi_ss_i;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
            sclk_s1 <= spi_sclk_i;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= spi_mosi_i;
            mosi_s2 <= mosi_s1;
        end
    end

    assign ss_fall   =  ss_d   & ~ss_s2;
    assign ss_rise   = ~ss_d   &  ss_s2;
    assign sclk_rise = ~sclk_d &  sclk_s2;
    assign sclk_fall =  sclk_d & ~sclk_s2;

    assign rx_char     = {rx_sr[CHAR_LEN-2:0], mosi_s2};
    assign tx_load_val = tx_empty ? TX_IDLE_PAT : tx_head;

    // Decode the per-cycle load/complete events; ss deassertion masks sclk edges.
    always_comb begin
        tx_load     = 1'b0;
        rx_complete = 1'b0;
        case (state)
            IDLE: begin
                tx_load = ss_fall;
            end
            default: begin
                if (!ss_rise) begin
                    rx_complete = sclk_rise && (bit_cnt == CNT_W'(CHAR_LEN - 1));
                    tx_load     = sclk_fall && (bit_cnt == '0);
                end
            end
        endcase
    end

    assign tx_pop         = tx_load && !tx_empty;
    assign rx_pop         = rx_ready_i && !rx_empty;
    assign rx_overrun_set = rx_complete && rx_full && !rx_pop;

    // Transfer FSM: shift registers, bit counter and state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        tx_sr   <= tx_load_val;
                        bit_cnt <= '0;
                        state   <= ACTIVE;
                    end
                end
                default: begin
                    if (ss_rise) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else if (sclk_rise) begin
                        rx_sr <= rx_char;
                        if (rx_complete) begin
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        if (tx_load) begin
                            tx_sr <= tx_load_val;
                        end else begin
                            tx_sr <= {tx_sr[CHAR_LEN-2:0], 1'b0};
                        end
                    end
                end
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_overrun_o  <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            if (rx_overrun_set) begin
                rx_overrun_o <= 1'b1;
            end
            if (tx_load && tx_empty) begin
                tx_underrun_o <= 1'b1;
            end
        end
    end

    assign spi_miso_o = (state == ACTIVE) && tx_sr[CHAR_LEN-1];
    assign busy_o     = (state == ACTIVE);
    assign tx_ready_o = !tx_full;
    assign rx_valid_o = !rx_empty;

    spi_slave_fifo #(
        .WIDTH (CHAR_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (tx_valid_i && !tx_full),
        .push_data (tx_data_i),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    spi_slave_fifo #(
        .WIDTH (CHAR_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (rx_complete),
        .push_data (rx_char),
        .pop       (rx_pop),
        .pop_data  (rx_data_o),
        .full      (rx_full),
        .empty     (rx_empty)
    );
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a behavioural mode-0 SPI master
// (divider 8) plus FIFO push/pop helpers, checked against hand-computed values.
module tb_spi_slave_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got;

    spi_slave_responder #(
        .CHAR_LEN    (8),
        .FIFO_DEPTH  (4),
        .TX_IDLE_PAT (8'hFF)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .spi_ss_i      (ss),
        .spi_sclk_i    (sclk),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .rx_overrun_o  (rx_overrun),
        .tx_underrun_o (tx_underrun),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        cycles(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        check(tag, {31'd0, rx_valid}, 32'd1);
        check(tag, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
    endtask

    task automatic ss_begin();
        ss = 1'b0;
        cycles(8);
    endtask

    task automatic ss_end();
        cycles(4);
        ss = 1'b1;
        cycles(8);
    endtask

    // One character, MSB first; MISO sampled at the master's rising edge.
    task automatic spi_char(input logic [7:0] mo, input bit chk_lat, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            cycles(4);
            mi[i] = miso;
            sclk = 1'b1;
            if (i == 0 && chk_lat) begin
                cycles(2);
                check("rx_valid_lat2", {31'd0, rx_valid}, 32'd0);
                cycles(1);
                check("rx_valid_lat3", {31'd0, rx_valid}, 32'd1);
                cycles(1);
            end else begin
                cycles(4);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);
    endtask

    initial begin
        cycles(3);
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cycles(2);

        // Single character
        push_tx(8'hA5);
        ss_begin();
        check("single_busy", {31'd0, busy}, 32'd1);
        check("single_miso_msb", {31'd0, miso}, 32'd1);
        spi_char(8'h3C, 1'b1, got);
        check("single_miso_char", {24'd0, got}, 32'hA5);
        ss_end();
        check("single_busy_end", {31'd0, busy}, 32'd0);
        check("single_miso_idle", {31'd0, miso}, 32'd0);
        pop_rx("single_rx", 8'h3C);
        check("single_rx_empty", {31'd0, rx_valid}, 32'd0);

        // Burst of four under one ss
        do_reset();
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        check("burst_tx_full", {31'd0, tx_ready}, 32'd0);
        ss_begin();
        for (int i = 1; i <= 4; i++) begin
            spi_char(8'(i * 16), 1'b0, got);
            check("burst_miso", {24'd0, got}, i);
        end
        ss_end();
        check("burst_tx_ready", {31'd0, tx_ready}, 32'd1);
        for (int i = 1; i <= 4; i++) pop_rx("burst_rx", 8'(i * 16));
        check("burst_rx_empty", {31'd0, rx_valid}, 32'd0);

        // RX overrun
        do_reset();
        ss_begin();
        for (int i = 1; i <= 4; i++) spi_char(8'(i * 8'h11), 1'b0, got);
        check("ovr_before", {31'd0, rx_overrun}, 32'd0);
        spi_char(8'h55, 1'b0, got);
        ss_end();
        check("ovr_after", {31'd0, rx_overrun}, 32'd1);
        for (int i = 1; i <= 4; i++) pop_rx("ovr_rx", 8'(i * 8'h11));
        check("ovr_5th_lost", {31'd0, rx_valid}, 32'd0);

        // TX underrun
        do_reset();
        check("udr_before", {31'd0, tx_underrun}, 32'd0);
        ss_begin();
        check("udr_flag_load", {31'd0, tx_underrun}, 32'd1);
        spi_char(8'h96, 1'b0, got);
        ss_end();
        check("udr_miso", {24'd0, got}, 32'hFF);
        pop_rx("udr_rx", 8'h96);

        // Abort after five rising edges
        do_reset();
        push_tx(8'h81);
        push_tx(8'h42);
        ss_begin();
        for (int i = 7; i >= 3; i--) begin
            mosi = (i % 2 == 0);
            cycles(4);
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
        ss_end();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_no_rx", {31'd0, rx_valid}, 32'd0);
        ss_begin();
        spi_char(8'h5A, 1'b0, got);
        ss_end();
        check("abort_next_miso", {24'd0, got}, 32'h42);
        check("abort_next_rx", {31'd0, rx_valid}, 32'd1);
        check("abort_next_rx_data", {24'd0, rx_data}, 32'h5A);
        check("abort_underrun", {31'd0, tx_underrun}, 32'd1);

        // Async reset mid-character (RX still holds 5A, underrun sticky set)
        push_tx(8'hFF);
        ss_begin();
        for (int i = 7; i >= 5; i--) begin
            mosi = 1'b1;
            cycles(4);
            sclk = 1'b1;
            cycles(4);
            sclk = 1'b0;
        end
        cycles(4);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_miso", {31'd0, miso}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_miso", {31'd0, miso}, 32'd0);
        check("arst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("arst_rx_data", {24'd0, rx_data}, 32'd0);
        check("arst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("arst_tx_ready", {31'd0, tx_ready}, 32'd1);
        ss = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        push_tx(8'hC3);
        ss_begin();
        spi_char(8'h3C, 1'b0, got);
        ss_end();
        check("post_rst_miso", {24'd0, got}, 32'hC3);
        pop_rx("post_rst_rx", 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- Synthesizable SPI slave that sits directly downstream of the Wishbone SPI master's pads.
- Consumes the master's slave-select, serial clock and MOSI, and produces the MISO bit the master samples.
- Everything is oversampled in the master's system clock domain. Receive and transmit are buffered in small FIFOs behind valid/ready handshakes.
- Used as the on-board loopback/peripheral model in the SPI subsystem and as the DUT-side partner for master regressions.

Parameters:
- CHAR_LEN, 8, bits per SPI character (2..32).
- FIFO_DEPTH, 4, entries in each of the RX and TX FIFOs (power of two, ≥2).
- TX_IDLE_PAT, 8'hFF, pattern shifted out when the TX FIFO is empty at load time. Width is CHAR_LEN; the default assumes CHAR_LEN=8 and must be resized with it.

Ports:
- wb_clk_i  in  1  system clock; one clock, shared with the SPI master.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- spi_ss_i  in  1  slave select, active-low; wired to one bit of the master's ss_pad_o.
- spi_sclk_i  in  1  serial clock from the master's sclk_pad_o.
- spi_mosi_i  in  1  serial data from the master's mosi_pad_o.
- spi_miso_o  out  1  serial data to the master's miso_pad_i.
- tx_data_i  in  CHAR_LEN  character to transmit.
- tx_valid_i  in  1  TX push request.
- tx_ready_o  out  1  TX FIFO not full.
- rx_data_o  out  CHAR_LEN  head of the RX FIFO.
- rx_valid_o  out  1  RX FIFO not empty.
- rx_ready_i  in  1  RX pop.
- rx_overrun_o  out  1  sticky: a received character was dropped because the RX FIFO was full.
- tx_underrun_o  out  1  sticky: TX_IDLE_PAT was loaded because the TX FIFO was empty.
- busy_o  out  1  FSM in ACTIVE.

Behaviour:
- Reset (async, wb_rst_i=1) sets:
  - spi_miso_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0.
  - Both sticky flags=0, busy_o=0.
  - FIFOs empty, bit counter=0, synchronizers all at their idle level (ss=1, sclk=0, mosi=0).
- Input synchronization and edge detection:
  - spi_ss_i, spi_sclk_i and spi_mosi_i each pass through a 2-flop synchronizer.
  - Edges are detected on the synchronized value versus its one-cycle-delayed copy. Detection latency is 3 wb_clk_i cycles.
  - Requirement on the master: sclk half-period ≥ 4 wb_clk_i cycles (SPI divider ≥ 8).
- SPI mode is fixed: mode 0 (CPOL=0, CPHA=0), MSB first.
- FSM states IDLE and ACTIVE.
- IDLE:
  - spi_miso_o=0.
  - On a synchronized ss falling edge: load the TX shift register, clear the bit counter, go to ACTIVE.
  - Load = pop the TX FIFO head if it is non-empty; otherwise take TX_IDLE_PAT and set tx_underrun_o.
  - spi_miso_o presents the MSB in the cycle after the load.
- ACTIVE:
  - sclk rising edge: shift the synchronized mosi into the RX shift register LSB; increment the bit counter.
  - On the CHAR_LEN-th rising edge: push the completed character into the RX FIFO in the same cycle and reset the counter to 0. If the RX FIFO is full, drop the character and set rx_overrun_o.
  - sclk falling edge with counter≠0: shift the TX register left and drive the next bit on spi_miso_o.
  - sclk falling edge with counter=0 (character boundary): perform a new load, same rule as IDLE.
  - ss rising edge: go to IDLE. Any partial RX character is discarded and not pushed. A partially sent TX character counts as consumed and is not re-queued. spi_miso_o=0 the next cycle.
- FIFOs:
  - Synchronous, first-word fall-through.
  - A push while full is ignored; tx_ready_o=0 while full.
  - A pop with rx_ready_i=1 and rx_valid_o=1 advances the head.
  - A simultaneous push and pop while full is allowed for RX: the pop frees space and the push is accepted in the same cycle, with no overrun.
  - Pointers wrap modulo FIFO_DEPTH; a count register of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- Simultaneous events:
  - ss rising on the same cycle as a sclk edge: ss wins and the sclk edge is ignored.
  - An ss falling edge while in ACTIVE cannot occur and is ignored.
- Reset mid-transfer returns everything to reset values immediately, including FIFO contents.
- Sticky flags clear only on reset.

Test Plan:
- Single character: TX FIFO preloaded with 8'hA5; master sends 8'h3C with divider 8 → MISO bits 1,0,1,0,0,1,0,1 seen by the master, which receives 8'hA5; rx_data_o=8'h3C with rx_valid_o=1 three cycles after the 8th rising sclk.
- Burst of four characters under one ss with TX 8'h01..8'h04 and MOSI 8'h10..8'h40 → master receives 01..04; RX FIFO holds 10,20,30,40; tx_ready_o=1 after the transfer.
- RX overrun: rx_ready_i=0 and five characters sent with FIFO_DEPTH=4 → FIFO holds the first four; rx_overrun_o=1 after the 5th character; the 5th character is lost.
- TX underrun: empty TX FIFO and one character sent → master receives 8'hFF and tx_underrun_o=1.
- Abort: ss deasserted after 5 sclk rising edges → no RX push; busy_o=0; next transfer receives the full next character correctly and TX uses the following FIFO entry.
- Async reset asserted mid-character → all outputs take reset values without a clock edge; a subsequent clean transfer works.
